// File: rtl/cv32e40p_uart_tx_periph.sv
// Memory-mapped UART transmitter: bus register window, TX byte FIFO and
// an 8N1 serialiser with a programmable clocks-per-bit divider.
module cv32e40p_uart_tx_periph #(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned DEFAULT_BAUD_DIV = 434
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  uart_tx_o,
  output logic                  irq_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OFF_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      div_q, div_d;
  logic             tx_q, tx_d;

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic [15:0]      baud_div_q, baud_div_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic             rvalid_q;
  logic [31:0]      rdata_q, rdata_d;

  logic [OFF_W-1:0] off_c;
  logic             sel_tx_c, sel_status_c, sel_baud_c, sel_ctrl_c;
  logic             wr_c, push_req_c, push_c, pop_c;
  logic             full_c, empty_c, busy_c, baud_end_c;
  logic [15:0]      baud_wr_c;
  logic [31:0]      status_c;
  logic             unused_bits;

  assign gnt_o     = req_i;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign uart_tx_o = tx_q;
  assign irq_o     = irq_q;

  assign unused_bits = ^{addr_i[1:0], be_i[3:2], wdata_i[31:16]};

  // Register decode on word offset
  assign off_c        = addr_i[ADDR_WIDTH-1:2];
  assign sel_tx_c     = (off_c == OFF_W'(0));
  assign sel_status_c = (off_c == OFF_W'(1));
  assign sel_baud_c   = (off_c == OFF_W'(2));
  assign sel_ctrl_c   = (off_c == OFF_W'(3));
  assign wr_c         = req_i & we_i;

  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign busy_c     = (state_q != S_IDLE);
  assign push_req_c = wr_c & sel_tx_c & be_i[0];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_c     = push_req_c & (~full_c | pop_c);
  assign baud_end_c = (baud_cnt_q == div_q - 16'd1);

  assign status_c = 32'({count_q, 4'b0000, ovf_q, busy_c, empty_c, full_c});
  assign baud_wr_c = {be_i[1] ? wdata_i[15:8] : baud_div_q[15:8],
                      be_i[0] ? wdata_i[7:0]  : baud_div_q[7:0]};

  // Serialiser next-state
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    pop_c      = 1'b0;
    tx_d       = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c      = 1'b1;
          shift_d    = fifo_q[rd_ptr_q];
          div_d      = baud_div_q;
          baud_cnt_d = 16'd0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_cnt_d = 16'd0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_c) begin
          baud_cnt_d = 16'd0;
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            div_d   = baud_div_q;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level follows the state being entered so the pin is registered
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shift_d[0];
    end
  end

  // Register file and FIFO occupancy next-state
  always_comb begin
    baud_div_d = baud_div_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    rdata_d    = 32'd0;
    if (wr_c && sel_baud_c && (be_i[1:0] != 2'b00)) begin
      baud_div_d = (baud_wr_c == 16'd0) ? 16'd1 : baud_wr_c;
    end
    if (wr_c && sel_ctrl_c && be_i[0]) begin
      irq_en_d = wdata_i[0];
    end
    if (push_req_c && full_c && !pop_c) begin
      ovf_d = 1'b1;
    end else if (wr_c && sel_status_c && be_i[0] && wdata_i[3]) begin
      ovf_d = 1'b0;
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
    if (req_i && !we_i) begin
      if (sel_status_c) begin
        rdata_d = status_c;
      end else if (sel_baud_c) begin
        rdata_d = 32'(baud_div_q);
      end else if (sel_ctrl_c) begin
        rdata_d = 32'(irq_en_q);
      end
    end
    irq_d = irq_en_q & empty_c & ~busy_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      div_q      <= 16'(DEFAULT_BAUD_DIV);
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      baud_div_q <= 16'(DEFAULT_BAUD_DIV);
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      tx_q       <= tx_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      baud_div_q <= baud_div_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      rvalid_q   <= req_i;
      rdata_q    <= rdata_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (push_c) fifo_q[wr_ptr_q] <= wdata_i[7:0];
  end

endmodule

// File: tb/tb_cv32e40p_uart_tx_periph.sv
// Directed bench for cv32e40p_uart_tx_periph: register access, 8N1 framing,
// back-to-back frames, FIFO overflow, interrupt timing and async reset.
module tb_cv32e40p_uart_tx_periph;

  localparam logic [3:0] A_TX     = 4'h0;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_BAUD   = 4'h8;
  localparam logic [3:0] A_CTRL   = 4'hC;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [3:0]  addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        uart_tx_o;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  cv32e40p_uart_tx_periph #(
    .ADDR_WIDTH(4), .FIFO_DEPTH(8), .DEFAULT_BAUD_DIV(434)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .uart_tx_o(uart_tx_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one request for one cycle, returns at the next negedge
  task automatic bus(input logic w, input logic [3:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic [31:0] exp,
                     input logic [31:0] mask, input string tag);
    req_i = 1'b1; we_i = w; addr_i = a; be_i = b; wdata_i = d;
    #1 chk({tag, "/gnt"}, 32'(gnt_o), 32'd1);
    @(negedge clk_i);
    chk({tag, "/rvalid"}, 32'(rvalid_o), 32'd1);
    chk({tag, "/rdata"}, rdata_o & mask, exp);
    req_i = 1'b0; we_i = 1'b0; addr_i = 4'h0; be_i = 4'h0; wdata_i = 32'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d, input string tag);
    bus(1'b1, a, b, d, 32'd0, 32'hFFFF_FFFF, tag);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, a, 4'hF, 32'd0, exp, 32'hFFFF_FFFF, tag);
  endtask

  task automatic rdm(input logic [3:0] a, input logic [31:0] exp, input logic [31:0] mask, input string tag);
    bus(1'b0, a, 4'hF, 32'd0, exp, mask, tag);
  endtask

  // Expected line level for bit slot idx of an 8N1 frame carrying byte b
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  initial begin
    int n;
    int lows;
    rst_ni = 1'b1; req_i = 1'b0; addr_i = 4'h0; we_i = 1'b0; be_i = 4'h0; wdata_i = 32'd0;
    #2 rst_ni = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst/gnt", 32'(gnt_o), 32'd0);
    chk("rst/rvalid", 32'(rvalid_o), 32'd0);
    chk("rst/rdata", rdata_o, 32'd0);
    chk("rst/tx", 32'(uart_tx_o), 32'd1);
    chk("rst/irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(A_STATUS, 32'h2, "rst/status");
    rd(A_BAUD, 32'd434, "rst/baud");
    rd(A_TX, 32'd0, "rd_txdata");
    @(negedge clk_i);
    chk("idle/rvalid", 32'(rvalid_o), 32'd0);
    chk("idle/gnt", 32'(gnt_o), 32'd0);

    // BAUD_DIV boundaries: zero stored as one, byte enables honoured
    wr(A_BAUD, 4'h3, 32'd0, "baud0");
    rd(A_BAUD, 32'd1, "baud0/rd");
    wr(A_BAUD, 4'h3, 32'd4, "baud4");
    wr(A_BAUD, 4'h2, 32'h0000_12FF, "baud_be1");
    rd(A_BAUD, 32'h0000_1204, "baud_be1/rd");
    wr(A_BAUD, 4'h3, 32'd4, "baud4b");
    rd(A_BAUD, 32'd4, "baud4/rd");

    // Single frame 0xA5 at 4 clocks per bit
    wr(A_TX, 4'h1, 32'hA5, "tx_a5");
    chk("a5/pre", 32'(uart_tx_o), 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      chk($sformatf("a5/bit%0d", k), 32'(uart_tx_o), 32'(frame_bit(8'hA5, k / 4)));
    end
    @(negedge clk_i);
    chk("a5/post", 32'(uart_tx_o), 32'd1);
    rd(A_STATUS, 32'h2, "a5/status");

    // Three back-to-back frames at 2 clocks per bit
    wr(A_BAUD, 4'h3, 32'd2, "baud2");
    wr(A_TX, 4'h1, 32'h01, "tx_01");
    wr(A_TX, 4'h1, 32'h02, "tx_02");
    wr(A_TX, 4'h1, 32'h03, "tx_03");
    n = 2;
    while (n <= 61) begin
      if (n <= 60)
        chk($sformatf("b2b/n%0d", n), 32'(uart_tx_o),
            32'(frame_bit(8'((n - 1) / 20 + 1), ((n - 1) % 20) / 2)));
      else
        chk("b2b/idle", 32'(uart_tx_o), 32'd1);
      if (n == 2) begin
        rd(A_STATUS, 32'h204, "b2b/cnt2");
      end else if (n == 25) begin
        rd(A_STATUS, 32'h104, "b2b/cnt1");
      end else if (n == 45) begin
        rd(A_STATUS, 32'h006, "b2b/cnt0");
      end else begin
        @(negedge clk_i);
      end
      n++;
    end
    rd(A_STATUS, 32'h2, "b2b/status");

    // Interrupt: enable while idle, drop on write, return after the frame
    chk("irq/off", 32'(irq_o), 32'd0);
    wr(A_CTRL, 4'h1, 32'd1, "ctrl1");
    @(negedge clk_i);
    chk("irq/on", 32'(irq_o), 32'd1);
    wr(A_TX, 4'h1, 32'h55, "tx_55");
    chk("irq/still", 32'(irq_o), 32'd1);
    for (int k = 3; k <= 24; k++) begin
      @(negedge clk_i);
      chk($sformatf("irq/n%0d", k), 32'(irq_o), (k == 24) ? 32'd1 : 32'd0);
    end
    rd(A_CTRL, 32'd1, "ctrl/rd");
    wr(A_CTRL, 4'h1, 32'd0, "ctrl0");
    @(negedge clk_i);
    chk("irq/disabled", 32'(irq_o), 32'd0);

    // Overflow: ten writes while a slow frame is in flight
    wr(A_BAUD, 4'h3, 32'd1000, "baud1000");
    wr(A_TX, 4'h1, 32'h00, "ovf/w0");
    for (int i = 1; i < 10; i++) wr(A_TX, 4'h1, 32'(8'h11 * i), $sformatf("ovf/w%0d", i));
    rdm(A_STATUS, 32'h00D, 32'h7FF, "ovf/status");
    wr(A_STATUS, 4'h0, 32'h8, "ovf/clr_be0");
    rdm(A_STATUS, 32'h00D, 32'h7FF, "ovf/kept");
    wr(A_STATUS, 4'h1, 32'h8, "ovf/clr");
    rdm(A_STATUS, 32'h005, 32'h7FF, "ovf/cleared");

    // Reset mid-DATA (first data bit of byte 0x00)
    repeat (1486) @(negedge clk_i);
    chk("mid/data", 32'(uart_tx_o), 32'd0);
    rst_ni = 1'b0;
    #1;
    chk("mid/rst_tx", 32'(uart_tx_o), 32'd1);
    chk("mid/rst_irq", 32'(irq_o), 32'd0);
    chk("mid/rst_rvalid", 32'(rvalid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    rd(A_STATUS, 32'h2, "post/status");
    rd(A_BAUD, 32'd434, "post/baud");
    lows = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_i);
      if (uart_tx_o !== 1'b1) lows++;
    end
    chk("post/no_frame", 32'(lows), 32'd0);
    rd(A_STATUS, 32'h2, "post/status2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
